// File: rtl/nrd_seq_div_pkg.sv
// Shared constants for the sequential non-restoring divider.
package nrd_pkg;

  // FSM encodings
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  localparam int unsigned DEFAULT_WIDTH = 8;

  // Quotient reported on divide-by-zero; sliced down to the operand width at use.
  localparam logic [63:0] DZ_QUO_ALL = '1;

endpackage

// File: rtl/nrd_seq_div_if.sv
// Controller <-> divider handshake and operand/result bundle.
interface nrd_seq_div_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic             signed_mode;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] rem;
  logic             div_by_zero;
  logic             ovf;

  modport master (
    output start, signed_mode, dividend, divisor,
    input  busy, done, quo, rem, div_by_zero, ovf
  );

  modport slave (
    input  start, signed_mode, dividend, divisor,
    output busy, done, quo, rem, div_by_zero, ovf
  );
endinterface

// File: rtl/nrd_seq_div_step.sv
// One non-restoring iteration: shift {A,Q} left, add or subtract M by the sign of A,
// and shift in the new quotient bit.
module nrd_step #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH:0]   a,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] m,
  output logic [WIDTH:0]   a_n,
  output logic [WIDTH-1:0] q_n
);

  logic [WIDTH:0] a_sh;
  logic [WIDTH:0] m_ext;

  // Sign of the pre-shift partial remainder selects restore-by-add vs subtract.
  always_comb begin
    a_sh  = {a[WIDTH-1:0], q[WIDTH-1]};
    m_ext = {1'b0, m};
    a_n   = a[WIDTH] ? (a_sh + m_ext) : (a_sh - m_ext);
    q_n   = {q[WIDTH-2:0], ~a_n[WIDTH]};
  end

endmodule

// File: rtl/nrd_seq_div.sv
// Multi-cycle non-restoring divider, one quotient bit per clock, with unsigned and
// signed (truncating) modes, divide-by-zero and signed-overflow flags.
module nrd_seq_div
  import nrd_pkg::*;
#(
  parameter int unsigned WIDTH     = DEFAULT_WIDTH,
  parameter bit          SIGNED_EN = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  nrd_seq_div_if.slave bus
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] MinNeg = {1'b1, {(WIDTH - 1){1'b0}}};

  logic [1:0]       state_q, state_d;
  logic [WIDTH:0]   a_q;
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] m_q;
  logic [WIDTH-1:0] dvd_q;
  logic [CntW-1:0]  cnt_q;
  logic             qneg_q, rneg_q, dz_q, ovf_pend_q;

  logic [WIDTH-1:0] quo_q, rem_q;
  logic             dbz_q, ovf_q;

  logic             accept;
  logic             sgn, sd, sv, zero_in;
  logic [WIDTH-1:0] dvd_mag, dvs_mag;
  logic [WIDTH:0]   a_step;
  logic [WIDTH-1:0] q_step;
  logic [WIDTH-1:0] rem_mag, quo_fix, rem_fix;

  // Operand decode on accept: sign extraction and magnitudes.
  always_comb begin
    accept  = bus.start && ((state_q == IDLE) || (state_q == DONE));
    sgn     = SIGNED_EN && bus.signed_mode;
    sd      = sgn && bus.dividend[WIDTH-1];
    sv      = sgn && bus.divisor[WIDTH-1];
    dvd_mag = sd ? (~bus.dividend + 1'b1) : bus.dividend;
    dvs_mag = sv ? (~bus.divisor + 1'b1) : bus.divisor;
    zero_in = (bus.divisor == '0);
  end

  nrd_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .a   (a_q),
    .q   (q_q),
    .m   (m_q),
    .a_n (a_step),
    .q_n (q_step)
  );

  // Final remainder restore and sign correction.
  always_comb begin
    rem_mag = a_q[WIDTH] ? (a_q[WIDTH-1:0] + m_q) : a_q[WIDTH-1:0];
    quo_fix = qneg_q ? (~q_q + 1'b1) : q_q;
    rem_fix = rneg_q ? (~rem_mag + 1'b1) : rem_mag;
  end

  // FSM next state; a start in DONE chains straight into the next operation.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (bus.start) state_d = zero_in ? FIX : RUN;
      RUN:  if (cnt_q == CntW'(WIDTH - 1)) state_d = FIX;
      FIX:  state_d = DONE;
      DONE: begin
        if (bus.start) state_d = zero_in ? FIX : RUN;
        else           state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Working registers: load on accept, iterate in RUN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q        <= '0;
      q_q        <= '0;
      m_q        <= '0;
      dvd_q      <= '0;
      cnt_q      <= '0;
      qneg_q     <= 1'b0;
      rneg_q     <= 1'b0;
      dz_q       <= 1'b0;
      ovf_pend_q <= 1'b0;
    end else if (accept) begin
      a_q        <= '0;
      q_q        <= dvd_mag;
      m_q        <= dvs_mag;
      dvd_q      <= bus.dividend;
      cnt_q      <= '0;
      qneg_q     <= sd ^ sv;
      rneg_q     <= sd;
      dz_q       <= zero_in;
      ovf_pend_q <= sgn && (bus.dividend == MinNeg) && (bus.divisor == '1);
    end else if (state_q == RUN) begin
      a_q   <= a_step;
      q_q   <= q_step;
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Result registers: flags clear on accept, everything written in FIX and held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      quo_q <= '0;
      rem_q <= '0;
      dbz_q <= 1'b0;
      ovf_q <= 1'b0;
    end else if (accept) begin
      dbz_q <= 1'b0;
      ovf_q <= 1'b0;
    end else if (state_q == FIX) begin
      if (dz_q) begin
        quo_q <= DZ_QUO_ALL[WIDTH-1:0];
        rem_q <= dvd_q;
        dbz_q <= 1'b1;
      end else begin
        // Overflow needs no special path: |MIN| fits the unsigned quotient and wraps.
        quo_q <= quo_fix;
        rem_q <= rem_fix;
        ovf_q <= ovf_pend_q;
      end
    end
  end

  assign bus.busy        = (state_q == RUN) || (state_q == FIX);
  assign bus.done        = (state_q == DONE);
  assign bus.quo         = quo_q;
  assign bus.rem         = rem_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.ovf         = ovf_q;

endmodule
